// File: rtl/updown_hex_pkg.sv
// updown_hex_pkg: seven-segment glyph constants and hex decode shared by the hex scan display.
package updown_hex_pkg;
  localparam logic [6:0] SEG_0 = 7'h7E, SEG_1 = 7'h30, SEG_2 = 7'h6D, SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33, SEG_5 = 7'h5B, SEG_6 = 7'h5F, SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F, SEG_9 = 7'h7B, SEG_A = 7'h77, SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E, SEG_D = 7'h3D, SEG_E = 7'h4F, SEG_F = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      4'hF: return SEG_F;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/updown_hex_scan_hex7seg.sv
// hex7seg: combinational hex nibble to active-high abcdefg segment decoder.
module hex7seg
  import updown_hex_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nib);
endmodule

// File: rtl/updown_hex_scan.sv
// updown_hex_scan: up/down hex counter with load/hold, wrap or saturate, Gray output and scanned 7-segment display.
module updown_hex_scan
  import updown_hex_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16,
  parameter int SAT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                x,
  input  logic                h,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] count_gray,
  output logic                limit,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);
  localparam int W  = 4 * DIGITS;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam bit SAT = SAT_MODE != 0;
  logic          at_max, at_min, scan_wrap;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx, dig_next;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  assign at_max     = &count;
  assign at_min     = ~|count;
  assign count_gray = count ^ (count >> 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      limit <= 1'b0;
    end else if (load) begin
      count <= load_val;
      limit <= 1'b0;
    end else if (h) begin
      limit <= 1'b0;
    end else if (x) begin
      limit <= at_max;
      count <= (at_max && SAT) ? count : count + W'(1);
    end else begin
      limit <= at_min;
      count <= (at_min && SAT) ? count : count - W'(1);
    end
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  assign dig_next  = !scan_wrap ? dig_idx : (dig_idx == IW'(DIGITS - 1) ? '0 : dig_idx + IW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      dig_idx  <= dig_next;
    end
  // Decode against the upcoming digit so an and seg switch on the same edge.
  assign nib = 4'(count >> (4 * dig_next));
  hex7seg u_dec (.nib(nib), .seg(seg_d));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg <= SEG_0;
      an  <= DIGITS'(1);
    end else begin
      seg <= seg_d;
      an  <= DIGITS'(1) << dig_next;
    end
endmodule

// File: doc/updown_hex_scan.md
# updown_hex_scan

Parametrised up/down hex counter with load, hold, wrap/saturate mode and Gray-coded output, driving a time-multiplexed, multi-digit 7-segment display. It is the successor to the single-digit up/down display counter: the same count and display function, widened to DIGITS hex digits, with one shared segment bus scanned across the digits. It sits between board switches/debounced inputs and the on-board 7-segment display.

## Interface

Parameters:
- DIGITS, 4: number of hex digits. Counter width W = 4*DIGITS. Legal range 1..8.
- SCAN_DIV, 16: clock cycles each digit is shown. Must be ≥ 2.
- SAT_MODE, 0: 0 = wrap at limits; 1 = saturate at limits.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- x, in, 1: direction; 1 = count up, 0 = count down.
- h, in, 1: hold; 1 freezes the count.
- load, in, 1: synchronous load of load_val.
- load_val, in, W: value loaded when load=1.
- count, out, W: binary count.
- count_gray, out, W: count ^ (count >> 1), combinational from count.
- limit, out, 1: one-cycle pulse on wrap, or on a blocked step at saturation.
- seg, out, 7: segments {a,b,c,d,e,f,g}, bit 6 = a, active-high.
- an, out, DIGITS: one-hot digit enable, active-high; an[0] = least-significant digit.

## Operation

- Priority each cycle: load > h > step.
  - load=1: count ← load_val; limit=0.
  - h=1 (and no load): count holds; limit=0.
  - Otherwise, step by ±1 per x.
- Up step at count = 2^W−1:
  - SAT_MODE=0: count ← 0, limit=1.
  - SAT_MODE=1: count stays, limit=1.
- Down step at count = 0:
  - SAT_MODE=0: count ← 2^W−1, limit=1.
  - SAT_MODE=1: count stays, limit=1.
- Width rule: all arithmetic is modulo 2^W. No carry beyond W.
- Scan:
  - scan_cnt counts 0..SCAN_DIV−1, then wraps to 0.
  - When scan_cnt wraps, dig_idx advances 0→1→…→DIGITS−1→0.
  - an = 1 << dig_idx.
- seg is the decode of nibble count[4*dig_idx +: 4]. Decode (abcdefg, hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- DIGITS=1: an stays 1'b1; seg follows count with no scanning.

## Timing

- Reset (asynchronous assert, synchronous to clk on release): count=0, count_gray=0, limit=0, scan_cnt=0, dig_idx=0, an=…0001, seg=7'h7E.
- count and limit are registered; the new value is visible the cycle after the enabling edge.
- seg and an are registered together, so they never disagree. seg reflects count as of the previous edge: one cycle of display latency.
- Reset mid-scan or mid-count: all state returns immediately to reset values. The first clk edge after release performs a normal step.
- load and a limit condition in the same cycle: load wins; no limit pulse.
- Counting is not gated by scanning; count can change several times within one digit period.

## Structure

- Package updown_hex_pkg:
  - SEG_* constants for the 16 glyphs and SEG_BLANK = 7'h00.
  - hex_to_seg function or the table.
- Sub-module hex7seg: combinational 4-bit → 7-bit decoder using the package constants. Instantiated once, on the muxed nibble.
- Top level holds three processes:
  - counter with saturation/wrap logic;
  - scan divider and digit index;
  - registered seg/an output stage.

## Test plan

- Reset and scan: DIGITS=4, SCAN_DIV=4, hold rst_n=0 then release. Required: count=0, an=0001, seg=7E. an steps to 0010 after 4 cycles, reaches 1000 at cycle 12 and returns to 0001 at cycle 16.
- Wrap up/down (SAT_MODE=0): load 16'hFFFE, x=1 for 3 cycles. Required: count goes FFFF, 0000, 0001, with limit high for exactly one cycle on the FFFF→0000 step. Then x=0 from 0000: count=FFFF with one limit pulse.
- Saturate (SAT_MODE=1): load FFFF, x=1 for 3 cycles. Required: count stays FFFF and limit stays high on every cycle. At 0000 with x=0, likewise.
- Priority: h=1 and load=1 with load_val=16'h1234. Required: count=1234. Then h=1, load=0, x=1 for 5 cycles: count stays 1234.
- Display decode: load 16'hA5C0. Over one scan period, sample seg on each an value:
  - an=0001 → 7E
  - an=0010 → 4E
  - an=0100 → 5B
  - an=1000 → 77
- Gray and async reset: count=16'h0005 gives count_gray=16'h0007. Assert rst_n mid-scan with dig_idx=2. Required: an=0001, seg=7E and count=0 without waiting for a clk edge.
